frame_buffer: RTL
=================

# frame_buffer

Dual-port 256×256×12-bit pixel memory that serves the image read port of the rectangle/image overlay stage: it takes the 16-bit `pixel_addr` and returns `rgb_pixel` one clock later. A second port lets the measurement/plot logic write pixels through a valid/ready handshake. A built-in clear engine sweeps the whole buffer to a fixed colour on request. It sits between the voltage plot generator (writer) and the VGA draw pipeline (reader), all in the `pclk` domain.

## Interface
- `ADDR_WIDTH`, 16: address width; depth is 2^ADDR_WIDTH words; address = {y[7:0], x[7:0]}.
- `DATA_WIDTH`, 12: pixel width, RGB 4:4:4.
- `CLEAR_COLOR`, 12'h000: value written by the clear engine.

Ports:
- `pclk` in 1: pixel clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pixel_addr` in 16: read address from the draw stage.
- `rgb_pixel` out 12: registered read data.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write port can accept.
- `wr_x` in 8: write column.
- `wr_y` in 8: write row.
- `wr_rgb` in 12: write data.
- `clear_req` in 1: start a full-buffer clear; level-sampled.
- `clear_busy` out 1: clear in progress.
- `clear_done` out 1: one-cycle pulse when the clear completes.

## Operation
- Storage is 65536 × 12 and infers block RAM. Memory contents are not affected by `rst`; power-up contents are undefined.
- Read port:
  - Always active, independent of FSM state.
  - `rgb_pixel <= mem[pixel_addr]` every cycle.
  - Read-first: a same-cycle write to the same address returns the old data.
- Write port:
  - `wr_ready = (state == IDLE)`, decoded combinationally from the state register.
  - A transfer occurs on any edge where `wr_valid && wr_ready`, writing `mem[{wr_y, wr_x}] <= wr_rgb`.
  - The writer holds x, y and rgb stable while `wr_valid` is high and `wr_ready` is low.
- FSM states:
  - IDLE: write port open. When `clear_req` = 1, load `clr_addr` = 0 and go to CLEAR.
  - CLEAR: write `mem[clr_addr] <= CLEAR_COLOR` and increment `clr_addr` (16-bit) each cycle. After the write of address 0xFFFF, return to IDLE and pulse `clear_done`.
- `clear_busy = (state == CLEAR)`.
- `clear_req` is ignored while in CLEAR. If it is still high on the first IDLE cycle after completion, a new clear starts.
- `clear_req` and an accepted write on the same edge in IDLE: the write completes, then the clear starts next cycle and later overwrites it.
- `clr_addr` wraps 0xFFFF→0x0000 on completion. Its terminal count is detected on 0xFFFF, not on the wrap.
- Reset:
  - `rst` during CLEAR aborts the clear: state goes to IDLE and memory is left partially cleared.
  - Outputs on reset: `rgb_pixel` = 12'h000, `clear_busy` = 0, `clear_done` = 0, `clr_addr` = 0.
  - `wr_ready` = 1 from the first cycle after reset.

## Timing
- Read latency is exactly 1 clock: address sampled on edge k, data valid after edge k and held until edge k+1. This matches the draw stage, which registers `pixel_addr` one cycle and consumes `rgb_pixel` on the next.
- Write latency: a write accepted on edge k is visible on `rgb_pixel` after edge k+1, if addressed at k+1.
- Clear sequence:
  - `clear_req` sampled on edge k moves to CLEAR.
  - Address n is written on edge k+1+n.
  - The last write happens on edge k+65536.
  - `clear_busy` is high for exactly 65536 cycles.
  - `clear_done` is high for the one cycle after edge k+65536, when `clear_busy` is already low and `wr_ready` is high.
- No combinational path from `pixel_addr` to `rgb_pixel`. `wr_ready` depends only on the state register, never on `wr_valid`.

## Test plan
- Reset: assert `rst` for 3 cycles mid-activity → `rgb_pixel` = 0x000, `clear_busy` = 0, `clear_done` = 0, `wr_ready` = 1 on the first post-reset cycle.
- Write/read: write x=0x05, y=0x03, rgb=0xABC, then drive `pixel_addr` = 0x0305 → `rgb_pixel` = 0xABC exactly one cycle after the address edge. Address 0x0306 still reads its prior value.
- Read-during-write: preload 0x0102 = 0x111, then write 0x222 to 0x0102 while reading it → same-cycle read returns 0x111, next read returns 0x222.
- Full clear: fill corners 0x0000, 0x00FF, 0xFF00, 0xFFFF with 0xFFF, then pulse `clear_req`:
  - `clear_busy` is high for 65536 cycles and `clear_done` pulses once.
  - All four corners read 0x000.
  - A writer holding `wr_valid` with 0x5A5 at 0x8080 throughout sees `wr_ready` = 0 and completes only after the clear, so a readback returns 0x5A5.
- Simultaneous events: `clear_req` and `wr_valid` (0x0A0A, 0x777) on the same IDLE edge → write is accepted, clear follows, final read of 0x0A0A = `CLEAR_COLOR`.
- Reset mid-clear: assert `rst` after 1000 clear cycles → `clear_busy` = 0 and no `clear_done` pulse; address 0x0000 = 0x000; an address above 0x1000 preloaded with 0xFFF still reads 0xFFF.

Source files
------------

// File: rtl/frame_buffer_if.sv
// frame_buffer_if: bundles the pixel read port, the handshaked write port and
// the clear-engine controls of frame_buffer.
//   pixel_addr  : read address {y, x} from the draw stage
//   rgb_pixel   : registered read data (1-cycle latency)
//   wr_valid/wr_ready, wr_x, wr_y, wr_rgb : pixel write handshake
//   clear_req   : level-sampled request for a full-buffer clear
//   clear_busy  : clear sweep in progress
//   clear_done  : one-cycle pulse once the sweep finishes
// Modports: master (writer/reader side), slave (the buffer itself).
interface frame_buffer_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0]   pixel_addr;
    logic [DATA_WIDTH-1:0]   rgb_pixel;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [ADDR_WIDTH/2-1:0] wr_x;
    logic [ADDR_WIDTH/2-1:0] wr_y;
    logic [DATA_WIDTH-1:0]   wr_rgb;
    logic                    clear_req;
    logic                    clear_busy;
    logic                    clear_done;

    modport master (
        output pixel_addr, wr_valid, wr_x, wr_y, wr_rgb, clear_req,
        input  rgb_pixel, wr_ready, clear_busy, clear_done
    );

    modport slave (
        input  pixel_addr, wr_valid, wr_x, wr_y, wr_rgb, clear_req,
        output rgb_pixel, wr_ready, clear_busy, clear_done
    );
endinterface

// File: rtl/frame_buffer.sv
// frame_buffer: dual-port 2^ADDR_WIDTH x DATA_WIDTH pixel memory.
// Read port is always active with one cycle of registered latency and
// read-first behaviour. The single write port is shared between the external
// valid/ready writer (accepted only in idle) and a clear engine that sweeps
// every address to CLEAR_COLOR, one address per cycle.
//   pclk : pixel clock, rising edge
//   rst  : synchronous, active-high reset (memory contents are not reset)
//   bus  : frame_buffer_if slave modport (read, write and clear signals)
module frame_buffer #(
    parameter int unsigned           ADDR_WIDTH  = 16,
    parameter int unsigned           DATA_WIDTH  = 12,
    parameter logic [DATA_WIDTH-1:0] CLEAR_COLOR = '0
) (
    input  logic          pclk,
    input  logic          rst,
    frame_buffer_if.slave bus
);

    typedef enum logic {StIdle, StClear} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  clear_done_q, clear_done_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rd_q;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= StIdle;
            clr_addr_q   <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            clear_done_q <= clear_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        clear_done_d = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = {bus.wr_y, bus.wr_x};
        mem_wdata    = bus.wr_rgb;
        unique case (state_q)
            StIdle: begin
                // wr_ready is 1 here, so wr_valid alone marks a transfer; a
                // same-edge clear request lets this write land first.
                mem_we = bus.wr_valid;
                if (bus.clear_req) begin
                    state_d    = StClear;
                    clr_addr_d = '0;
                end
            end
            StClear: begin
                mem_we     = 1'b1;
                mem_waddr  = clr_addr_q;
                mem_wdata  = CLEAR_COLOR;
                clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                // Terminal count on the last address; the counter wraps to 0.
                if (clr_addr_q == '1) begin
                    state_d      = StIdle;
                    clear_done_d = 1'b1;
                end
            end
        endcase
        // Reset aborts a sweep without touching the address being visited.
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge pclk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read-first: the nonblocking read sees the pre-write contents.
    always_ff @(posedge pclk) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[bus.pixel_addr];
        end
    end

    assign bus.rgb_pixel  = rd_q;
    assign bus.wr_ready   = (state_q == StIdle);
    assign bus.clear_busy = (state_q == StClear);
    assign bus.clear_done = clear_done_q;

endmodule
